// File: rtl/imem_pkg.sv
// imem_pkg: shared types, constants and helpers for the instruction memory fetch unit.
package imem_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    // Word returned for cleared memory and faulted fetches; decode treats it as NOP.
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam int          BYTE_LANE_W = 8;

    typedef struct packed {
        logic        valid;
        logic        fault;
        logic [31:0] data;
    } rsp_t;

    function automatic int idx_width(input int depth_bytes);
        return $clog2(depth_bytes / 4);
    endfunction

    // Big-endian lanes: be[3] covers [31:24] (byte at the word address), be[0] covers [7:0].
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{BYTE_LANE_W{be[3]}}, {BYTE_LANE_W{be[2]}},
                {BYTE_LANE_W{be[1]}}, {BYTE_LANE_W{be[0]}}};
    endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// imem_fetch_unit_if: fetch request/response and loader signals of the instruction memory.
interface imem_fetch_unit_if #(
    parameter int PC_W = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [PC_W-1:0] req_pc;
    logic            rsp_valid;
    logic [31:0]     rsp_instr;
    logic            rsp_fault;
    logic            ld_en;
    logic [PC_W-1:0] ld_addr;
    logic [31:0]     ld_data;
    logic [3:0]      ld_be;
    logic            init_busy;

    modport master (
        output req_valid, req_pc, ld_en, ld_addr, ld_data, ld_be,
        input  req_ready, rsp_valid, rsp_instr, rsp_fault, init_busy
    );

    modport slave (
        input  req_valid, req_pc, ld_en, ld_addr, ld_data, ld_be,
        output req_ready, rsp_valid, rsp_instr, rsp_fault, init_busy
    );
endinterface

// File: rtl/imem_rsp_pipe.sv
// imem_rsp_pipe: LAT-deep response shift register carrying {valid, fault, data}.
// Stage payloads only advance with a valid entry, so the output data holds between responses.
module imem_rsp_pipe
    import imem_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  rsp_t i_rsp,
    output rsp_t o_rsp
);
    rsp_t [LAT:0] w_stage;

    assign w_stage[0] = i_rsp;

    for (genvar s = 0; s < LAT; s++) begin : g_stage
        rsp_t r_rsp;

        // NOTE: non-blocking assignments make every stage sample its predecessor's pre-edge value.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_rsp <= '{valid: 1'b0, fault: 1'b0, data: NOP_WORD};
            end else begin
                r_rsp.valid <= w_stage[s].valid;
                if (w_stage[s].valid) begin
                    r_rsp.fault <= w_stage[s].fault;
                    r_rsp.data  <= w_stage[s].data;
                end
            end
        end

        assign w_stage[s+1] = r_rsp;
    end

    assign o_rsp = w_stage[LAT];
endmodule

// File: rtl/imem_fetch_unit.sv
// imem_fetch_unit: pipelined synchronous instruction memory that zeroes itself after reset.
// Define IMEM_FAULT_CHECK_EN to fault misaligned or out-of-range fetches instead of wrapping.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = 16384,
    parameter int READ_LAT    = 1,
    parameter int PC_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    imem_fetch_unit_if.slave bus
);
    localparam int DEPTH_WORDS = DEPTH_BYTES / 4;
    localparam int IDX_W       = idx_width(DEPTH_BYTES);

    state_e           r_state;
    logic [IDX_W-1:0] r_clr_idx;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic [PC_W-1:0]  w_req_pc;
    logic [PC_W-1:0]  w_ld_addr;
    logic [IDX_W-1:0] w_req_idx;
    logic [IDX_W-1:0] w_ld_idx;
    logic [31:0]      w_ld_mask;
    logic [31:0]      w_rd_word;
    logic             w_accept;
    logic             w_fault;
    logic             w_ld_we;
    logic             w_unused;
    rsp_t             w_pipe_in;
    rsp_t             w_pipe_out;

    assign w_req_pc  = bus.req_pc;
    assign w_ld_addr = bus.ld_addr;
    assign w_req_idx = w_req_pc[IDX_W+1:2];
    assign w_ld_idx  = w_ld_addr[IDX_W+1:2];
    assign w_ld_mask = be_to_mask(bus.ld_be);
    // Upper address bits and pc[1:0] only matter when fault checking is built in.
    assign w_unused  = &{1'b0, w_req_pc, w_ld_addr};

    // A load in the same cycle blocks the fetch, so the array sees one access per cycle.
    assign bus.req_ready = (r_state == RUN) && !bus.ld_en;
    assign bus.init_busy = (r_state == CLEAR);
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_ld_we       = (r_state == RUN) && bus.ld_en && !rst;

`ifdef IMEM_FAULT_CHECK_EN
    assign w_fault = (w_req_pc[1:0] != 2'b00) || (w_req_pc >= PC_W'(DEPTH_BYTES));
`else
    assign w_fault = 1'b0;
`endif

    // Read-first: the word is captured at acceptance, before any later load lands.
    assign w_rd_word = w_fault ? NOP_WORD : r_mem[w_req_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                r_state <= RUN;
            end
        end
    end

    // NOTE: the array has no reset branch; the CLEAR sweep zeroes it one word per cycle so it maps to RAM.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_mem[r_clr_idx] <= NOP_WORD;
        end else if (w_ld_we) begin
            r_mem[w_ld_idx] <= (r_mem[w_ld_idx] & ~w_ld_mask) | (bus.ld_data & w_ld_mask);
        end
    end

    assign w_pipe_in.valid = w_accept;
    assign w_pipe_in.fault = w_fault;
    assign w_pipe_in.data  = w_rd_word;

    imem_rsp_pipe #(
        .LAT (READ_LAT)
    ) u_rsp_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_rsp (w_pipe_in),
        .o_rsp (w_pipe_out)
    );

    assign bus.rsp_valid = w_pipe_out.valid;
    assign bus.rsp_fault = w_pipe_out.fault;
    assign bus.rsp_instr = w_pipe_out.data;
endmodule

// File: tb/tb_imem_fetch_unit.sv
// tb_imem_fetch_unit: table-driven load/fetch vectors with a response scoreboard,
// plus hand-written reset, collision and mid-run reset sequences.
module tb_imem_fetch_unit;
    import imem_pkg::*;

    localparam int DEPTH_BYTES = 256;
    localparam int READ_LAT    = 2;
    localparam int NW          = DEPTH_BYTES / 4;
`ifdef IMEM_FAULT_CHECK_EN
    localparam bit FC = 1'b1;
`else
    localparam bit FC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    imem_fetch_unit_if #(.PC_W(32)) bus ();

    imem_fetch_unit #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .READ_LAT    (READ_LAT),
        .PC_W        (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          due;
    } exp_t;

    typedef struct {
        bit          is_load;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_instr;
        logic        exp_fault;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest expectation at its due cycle.
    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rsp_valid with nothing outstanding", 32'(bus.rsp_valid), 32'(0));
            end else begin
                mon_e = sb.pop_front();
                check("rsp_instr", bus.rsp_instr, mon_e.instr);
                check("rsp_fault", 32'(bus.rsp_fault), 32'(mon_e.fault));
                check("rsp latency cycle", 32'(cyc), 32'(mon_e.due));
            end
        end else if (sb.size() != 0 && cyc >= sb[0].due) begin
            check("rsp_valid at due cycle", 32'(bus.rsp_valid), 32'(1));
            void'(sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.ld_en     = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.ld_be     = '0;
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] exp_i, input logic exp_f);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        bus.ld_en     = 1'b0;
        #1;
        check("req_ready for fetch", 32'(bus.req_ready), 32'(1));
        sb.push_back('{exp_i, exp_f, cyc + READ_LAT});
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus.req_valid = 1'b0;
        bus.ld_en     = 1'b1;
        bus.ld_addr   = addr;
        bus.ld_data   = data;
        bus.ld_be     = be;
        step();
        bus.ld_en     = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    // Counts init_busy cycles (bounded) and requires rsp_valid low throughout.
    task automatic count_busy(output int n);
        n = 0;
        while (bus.init_busy === 1'b1 && n < NW + 8) begin
            check("rsp_valid during clear", 32'(bus.rsp_valid), 32'(0));
            n++;
            step();
        end
    endtask

    task automatic drain();
        repeat (READ_LAT + 2) step();
        check("scoreboard drained", 32'(sb.size()), 32'(0));
    endtask

    function automatic vec_t ld(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        vec_t v;
        v.is_load = 1'b1; v.addr = a; v.data = d; v.be = be;
        v.exp_instr = '0; v.exp_fault = 1'b0;
        return v;
    endfunction

    function automatic vec_t fe(input logic [31:0] a, input logic [31:0] ei, input logic ef);
        vec_t v;
        v.is_load = 1'b0; v.addr = a; v.data = '0; v.be = '0;
        v.exp_instr = ei; v.exp_fault = ef;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n_busy;
        vec_t vecs[$];

        idle_inputs();
        step();
        step();

        // Reset: outputs cleared, init_busy for exactly NW cycles, inputs ignored meanwhile.
        pulse_reset();
        check("rsp_valid after reset", 32'(bus.rsp_valid), 32'(0));
        check("rsp_fault after reset", 32'(bus.rsp_fault), 32'(0));
        check("rsp_instr after reset", bus.rsp_instr, 32'h0);
        for (int i = 0; i < NW; i++) begin
            check("init_busy during clear", 32'(bus.init_busy), 32'(1));
            check("req_ready during clear", 32'(bus.req_ready), 32'(0));
            bus.req_valid = 1'b1;
            bus.req_pc    = 32'h20;
            bus.ld_en     = (i >= NW / 2);
            bus.ld_addr   = 32'h20;
            bus.ld_data   = 32'hFFFF_FFFF;
            bus.ld_be     = 4'hF;
            step();
        end
        check("init_busy after clear", 32'(bus.init_busy), 32'(0));
        idle_inputs();
        #1;
        check("req_ready in RUN", 32'(bus.req_ready), 32'(1));
        do_fetch(32'h20, 32'h0, 1'b0);
        drain();

        // Vector table: one row per cycle, fetches back to back.
        vecs.push_back(ld(32'd100,   32'h4808_0000, 4'hF));
        vecs.push_back(ld(32'd200,   32'h2413_0005, 4'hF));
        vecs.push_back(ld(32'h8,     32'hFFFF_FFFF, 4'hF));
        vecs.push_back(ld(32'h8,     32'h1122_3344, 4'b0101));
        vecs.push_back(ld(32'h0,     32'h1300_0001, 4'hF));
        vecs.push_back(ld(32'h30,    32'hDEAD_BEEF, 4'b0000));
        vecs.push_back(ld(32'h34,    32'hCAFE_F00D, 4'b1000));
        vecs.push_back(ld(32'h1FF,   32'h0BAD_F00D, 4'hF));
        vecs.push_back(fe(32'd100,   32'h4808_0000, 1'b0));
        vecs.push_back(fe(32'd200,   32'h2413_0005, 1'b0));
        vecs.push_back(fe(32'h8,     32'hFF22_FF44, 1'b0));
        vecs.push_back(fe(32'h30,    32'h0,         1'b0));
        vecs.push_back(fe(32'h34,    32'hCA00_0000, 1'b0));
        vecs.push_back(fe(32'h66,    FC ? 32'h0 : 32'h4808_0000, FC));
        vecs.push_back(fe(32'h4000,  FC ? 32'h0 : 32'h1300_0001, FC));
        vecs.push_back(fe(32'hFC,    32'h0BAD_F00D, 1'b0));
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_load) do_load(vecs[i].addr, vecs[i].data, vecs[i].be);
            else                 do_fetch(vecs[i].addr, vecs[i].exp_instr, vecs[i].exp_fault);
        end
        idle_inputs();
        drain();
        check("rsp_valid idle", 32'(bus.rsp_valid), 32'(0));
        check("rsp_instr holds last value", bus.rsp_instr, 32'h0BAD_F00D);

        // Load and fetch in the same cycle: fetch refused, load applied.
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'h10;
        bus.ld_en     = 1'b1;
        bus.ld_addr   = 32'h10;
        bus.ld_data   = 32'h5566_7788;
        bus.ld_be     = 4'hF;
        #1;
        check("req_ready with ld_en", 32'(bus.req_ready), 32'(0));
        step();
        idle_inputs();
        do_fetch(32'h10, 32'h5566_7788, 1'b0);

        // Fetch in flight, then a load to the same word: response shows the old word.
        do_load(32'h30, 32'hA1A2_A3A4, 4'hF);
        do_fetch(32'h30, 32'hA1A2_A3A4, 1'b0);
        do_load(32'h30, 32'hB1B2_B3B4, 4'hF);
        do_fetch(32'h30, 32'hB1B2_B3B4, 1'b0);
        idle_inputs();
        drain();

        // Mid-run reset with fetches in flight: both are flushed, clear runs in full.
        bus.req_valid = 1'b1;
        bus.req_pc    = 32'd100;
        step();
        bus.req_pc    = 32'd200;
        rst           = 1'b1;
        step();
        rst           = 1'b0;
        idle_inputs();
        count_busy(n_busy);
        check("clear length after mid-run reset", 32'(n_busy), 32'(NW));

        // Reset during CLEAR restarts the sweep from index 0.
        pulse_reset();
        repeat (10) step();
        pulse_reset();
        count_busy(n_busy);
        check("clear length after reset in CLEAR", 32'(n_busy), 32'(NW));
        do_fetch(32'd100, 32'h0, 1'b0);
        do_fetch(32'h8,   32'h0, 1'b0);
        idle_inputs();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
